gmux_qen_seq: RTL and testbench

- Sequencer feeding the quadrant enable inputs of the global clock mux.
- Converts a requested 4-quadrant clock-enable mask into a safe, timed sequence on the mux's dynamic-enable (DEN), dynamic-mode (DYNEN) and low-power (VLP) controls.
- Disables quadrants first, lets them settle, wakes quadrants out of low power, then enables them one at a time. This limits supply di/dt and avoids runt clocks.
- Sits directly upstream of the global clock mux in the clock-control fabric.

---
 rtl/gmux_qen_seq.sv | 176 +++++++++++++++++
 tb/tb_gmux_qen_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gmux_qen_seq.sv
// Quadrant enable sequencer for the global clock mux.
// Turns a requested 4-quadrant enable mask into a paced DEN/DYNEN/VLP
// sequence: disable, settle, drop into low power, wake, then enable the
// new quadrants one at a time to limit di/dt and avoid runt clocks.
module gmux_qen_seq #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned WAKE_CYCLES    = 8,
  parameter int unsigned STAGGER_CYCLES = 2,
  parameter int unsigned LP_EN          = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ_EN,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  output logic [3:0] DEN,
  output logic [3:0] DYNEN,
  output logic [3:0] VLP,
  output logic       BUSY,
  output logic       DONE
);

  localparam int unsigned MAX_SW = (SETTLE_CYCLES > WAKE_CYCLES) ? SETTLE_CYCLES : WAKE_CYCLES;
  localparam int unsigned MAX_C  = (MAX_SW > STAGGER_CYCLES) ? MAX_SW : STAGGER_CYCLES;
  localparam int unsigned CW     = (MAX_C < 2) ? 1 : $clog2(MAX_C);

  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LD   = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LD   = CW'(STAGGER_CYCLES - 1);
  localparam logic [3:0]    VLP_RST   = (LP_EN != 0) ? 4'hF : 4'h0;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_DIS, S_SETTLE, S_WAKE, S_EN, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    den_q, den_d;
  logic [3:0]    dynen_q, dynen_d;
  logic [3:0]    vlp_q, vlp_d;
  logic [3:0]    c_q, c_d;
  logic [3:0]    t_q, t_d;
  logic [3:0]    off_q, off_d;
  logic [3:0]    on_q, on_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Phase that follows the disable/settle part: wake only quadrants still in
  // low power, enable if anything is pending, otherwise finish.
  function automatic state_t after_off(input logic [3:0] on, input logic [3:0] vlp);
    if ((on & vlp) != 4'b0)  return S_WAKE;
    else if (on != 4'b0)     return S_EN;
    else                     return S_DONE;
  endfunction

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // Next state and next datapath values for each phase.
  always_comb begin
    logic [3:0] off_w, on_w, lsb, pend;
    state_d = state_q;
    den_d   = den_q;
    dynen_d = dynen_q;
    vlp_d   = vlp_q;
    c_d     = c_q;
    t_d     = t_q;
    off_d   = off_q;
    on_d    = on_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    off_w   = c_q & ~REQ_EN;
    on_w    = REQ_EN & ~c_q;
    lsb     = on_q & (~on_q + 4'd1);
    pend    = on_q;

    case (state_q)
      S_INIT: begin
        dynen_d = 4'hF;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (REQ_VALID) begin
          t_d   = REQ_EN;
          off_d = off_w;
          on_d  = on_w;
          if (off_w != 4'b0) state_d = S_DIS;
          else               state_d = after_off(on_w, vlp_q);
        end
      end
      S_DIS: begin
        den_d   = den_q & ~off_q;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          if (LP_EN != 0) vlp_d = vlp_q | off_q;
          state_d = after_off(on_q, vlp_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAKE: begin
        if (cnt_q == WAKE_LD) vlp_d = vlp_q & ~on_q;
        if (cnt_q == '0) state_d = S_EN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_EN: begin
        // Slot start raises the lowest pending bit; slot end either reloads
        // for the next bit or finishes once nothing is pending.
        if (cnt_q == STAG_LD) begin
          den_d = den_q | lsb;
          pend  = on_q & ~lsb;
          on_d  = pend;
        end
        if (cnt_q == '0) begin
          if (pend == 4'b0) state_d = S_DONE;
          else              cnt_d   = STAG_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        c_d     = t_q;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // Counters load on entry to a timed phase.
    if (state_d != state_q) begin
      case (state_d)
        S_SETTLE: cnt_d = SETTLE_LD;
        S_WAKE:   cnt_d = WAKE_LD;
        S_EN:     cnt_d = STAG_LD;
        default:  cnt_d = '0;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      den_q   <= '0;
      dynen_q <= '0;
      vlp_q   <= VLP_RST;
      c_q     <= '0;
      t_q     <= '0;
      off_q   <= '0;
      on_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      den_q   <= den_d;
      dynen_q <= dynen_d;
      vlp_q   <= vlp_d;
      c_q     <= c_d;
      t_q     <= t_d;
      off_q   <= off_d;
      on_q    <= on_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign REQ_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign DEN       = den_q;
  assign DYNEN     = dynen_q;
  assign VLP       = vlp_q;

endmodule

// File: tb/tb_gmux_qen_seq.sv
// Scoreboard bench for gmux_qen_seq: requests are pushed as transactions and
// a negedge monitor compares DEN/VLP/READY/BUSY/DONE each cycle against a
// timeline derived from the phase rules, popping on DONE.
module tb_gmux_qen_seq;

  localparam int SETTLE = 4;
  localparam int WAKE   = 8;
  localparam int STAG   = 2;

  typedef struct {
    logic [3:0] t;
    logic [3:0] c0;
    int         a;
  } txn_t;

  logic       CLK, RST;
  logic [3:0] REQ_EN;
  logic       REQ_VALID;
  logic       REQ_READY, BUSY, DONE;
  logic [3:0] DEN, DYNEN, VLP;

  logic [3:0] req_en0;
  logic       req_valid0;
  logic       l_ready, l_busy, l_done;
  logic [3:0] l_den, l_dynen, l_vlp;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 0;
  txn_t q[$];
  logic [3:0] mc = 4'h0;
  logic [3:0] mon_c = 4'h0;
  logic [3:0] prev_den = 4'h0;

  gmux_qen_seq #(
    .SETTLE_CYCLES(SETTLE), .WAKE_CYCLES(WAKE), .STAGGER_CYCLES(STAG), .LP_EN(1)
  ) u_dut (
    .CLK(CLK), .RST(RST), .REQ_EN(REQ_EN), .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY), .DEN(DEN), .DYNEN(DYNEN), .VLP(VLP),
    .BUSY(BUSY), .DONE(DONE)
  );

  gmux_qen_seq #(
    .SETTLE_CYCLES(SETTLE), .WAKE_CYCLES(WAKE), .STAGGER_CYCLES(STAG), .LP_EN(0)
  ) u_dut_nolp (
    .CLK(CLK), .RST(RST), .REQ_EN(req_en0), .REQ_VALID(req_valid0),
    .REQ_READY(l_ready), .DEN(l_den), .DYNEN(l_dynen), .VLP(l_vlp),
    .BUSY(l_busy), .DONE(l_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs k edges after the accept edge of x (LP enabled).
  function automatic void expect_at(input txn_t x, input int k,
                                    output logic [3:0] den, output logic [3:0] vlp,
                                    output int lat);
    logic [3:0] off, on, vlp0;
    int e;
    off  = x.c0 & ~x.t;
    on   = x.t & ~x.c0;
    vlp0 = ~x.c0;
    den  = x.c0;
    vlp  = vlp0;
    e    = 1;
    if (off != 4'h0) begin
      if (k >= e) den = den & ~off;
      e = e + 1 + SETTLE;
      if (k >= e - 1) vlp = vlp | off;
    end
    if ((on & vlp0) != 4'h0) begin
      if (k >= e) vlp = vlp & ~on;
      e = e + WAKE;
    end
    for (int i = 0; i < 4; i++) begin
      if (on[i]) begin
        if (k >= e) den[i] = 1'b1;
        e = e + STAG;
      end
    end
    lat = e;
  endfunction

  // Monitor: per-cycle comparison against the in-flight transaction.
  initial begin : monitor
    logic [3:0] ed, ev, rises, falls;
    int k, lat;
    bit eready, edone;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (q.size() > 0) begin
          k = cyc - q[0].a;
          expect_at(q[0], k, ed, ev, lat);
          eready = (k < 0) || (k >= lat);
          edone  = (k == lat);
        end else begin
          k = 0; lat = 0;
          ed = mon_c; ev = ~mon_c;
          eready = 1'b1; edone = 1'b0;
        end
        chk("den", DEN, ed);
        chk("vlp", VLP, ev);
        chk("req_ready", REQ_READY, eready);
        chk("busy", BUSY, !eready);
        chk("done", DONE, edone);
        chk("dynen", DYNEN, 4'hF);
        rises = DEN & ~prev_den;
        falls = prev_den & ~DEN;
        chk("inv_den_and_vlp", DEN & VLP, 4'h0);
        chk("inv_one_rise", $countones(rises) <= 1, 1);
        chk("inv_rise_with_fall", (rises != 4'h0) && (falls != 4'h0), 0);
        if (q.size() > 0 && k >= lat) begin
          mon_c = q[0].t;
          void'(q.pop_front());
        end
      end
      prev_den = DEN;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] t, input bit keep);
    int n;
    txn_t x;
    n = 0;
    REQ_EN = t;
    REQ_VALID = 1'b1;
    while (!REQ_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("accept_wait", REQ_READY, 1);
    if (REQ_READY) begin
      x.t = t; x.c0 = mc; x.a = cyc + 1;
      q.push_back(x);
      mc = t;
    end
    @(posedge CLK);
    @(negedge CLK);
    if (!keep) REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin : stim
    logic [3:0] t, eden;
    bit keep;
    RST = 1'b1;
    REQ_EN = 4'h0; REQ_VALID = 1'b0;
    req_en0 = 4'h0; req_valid0 = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_den", DEN, 4'h0);
    chk("rst_vlp", VLP, 4'hF);
    chk("rst_dynen", DYNEN, 4'h0);
    chk("rst_ready", REQ_READY, 0);
    chk("rst_busy", BUSY, 1);
    chk("rst_done", DONE, 0);
    chk("rst_nolp_vlp", l_vlp, 4'h0);
    RST = 1'b0;
    #1 chk("init_ready", REQ_READY, 0);
    @(negedge CLK);
    chk("idle_ready", REQ_READY, 1);
    chk("idle_dynen", DYNEN, 4'hF);
    #1 mon_en = 1'b1;
    @(negedge CLK);

    issue(4'b0011, 1'b0); drain();
    issue(4'b0110, 1'b0); drain();
    issue(4'b0110, 1'b0); drain();

    // Async reset two cycles into WAKE (C=0110 -> 1111 wakes bits 0 and 3).
    issue(4'b1111, 1'b0);
    repeat (2) @(negedge CLK);
    #2;
    mon_en = 1'b0;
    RST = 1'b1;
    #1;
    chk("midrst_den", DEN, 4'h0);
    chk("midrst_vlp", VLP, 4'hF);
    chk("midrst_busy", BUSY, 1);
    chk("midrst_ready", REQ_READY, 0);
    chk("midrst_done", DONE, 0);
    q.delete();
    mc = 4'h0; mon_c = 4'h0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1 chk("rerel_init_busy", BUSY, 1);
    @(negedge CLK);
    chk("rerel_ready", REQ_READY, 1);
    chk("rerel_dynen", DYNEN, 4'hF);
    #1 mon_en = 1'b1;
    @(negedge CLK);
    issue(4'b0101, 1'b0); drain();

    // Randomised requests, often with REQ_VALID held across requests.
    for (int i = 0; i < 40; i++) begin
      t = 4'($urandom_range(0, 15));
      keep = 1'($urandom_range(0, 1));
      issue(t, keep);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    REQ_VALID = 1'b0;
    drain();

    // LP_EN=0 instance: 0000 -> 1111, bits rise after edges 1,3,5,7.
    chk("nolp_ready", l_ready, 1);
    req_en0 = 4'hF; req_valid0 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    req_valid0 = 1'b0;
    chk("nolp_den_k0", l_den, 4'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      eden = 4'h0;
      for (int b = 0; b < 4; b++) if (1 + STAG * b <= k) eden[b] = 1'b1;
      chk("nolp_den", l_den, eden);
      chk("nolp_vlp", l_vlp, 4'h0);
      chk("nolp_done", l_done, (k == 1 + 4 * STAG) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
